fighter_motion_ctrl: RTL and testbench

Per-frame motion and animation controller for one fighter. It sits directly upstream of the fighter sprite renderer. On each frame-start pulse it samples the player keys and advances the run/jump state machine, horizontal position, vertical velocity with gravity, and run-cycle frame counter. It drives the registered sprite origin and animation selectors that the renderer uses to offset its ROM addressing.

---
 rtl/fighter_motion_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_fighter_motion_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fighter_motion_ctrl.sv
// fighter_motion_ctrl
//   Per-frame motion and animation controller for one fighter sprite.
//   Once per video frame (frame_start pulse) the player keys are sampled and
//   the run/jump state, horizontal position, vertical velocity, and run-cycle
//   animation are advanced. Between updates every output holds its value, so
//   the renderer never sees a mid-frame change.
//
// Ports
//   vga_clk      in   pixel clock, all state changes on its rising edge
//   reset_n      in   asynchronous active-low reset
//   frame_start  in   one-cycle update strobe (vblank start)
//   key_left     in   level, move left
//   key_right    in   level, move right
//   key_jump     in   level, jump (acts on its rising edge across updates)
//   SpriteX      out  [9:0] sprite top-left X
//   SpriteY      out  [9:0] sprite top-left Y
//   anim_state   out  [1:0] 0 IDLE, 1 RUN, 2 AIR
//   anim_frame   out  [1:0] frame index within anim_state
//   facing_left  out  1 = mirror the sprite
//   update_done  out  pulses the cycle the new outputs become visible
//
// state | meaning
// ------+-----------------------------------------------
// IDLE  | on the ground, no direction held
// RUN   | on the ground, moving; run cycle animates
// AIR   | airborne; gravity integrates vy until landing
module fighter_motion_ctrl #(
  parameter int X_START    = 100,
  parameter int X_MIN      = 0,
  parameter int X_MAX      = 599,
  parameter int Y_GROUND   = 400,
  parameter int RUN_STEP   = 2,
  parameter int JUMP_V     = 12,
  parameter int GRAVITY    = 1,
  parameter int ANIM_DIV   = 6,
  parameter int RUN_FRAMES = 4
) (
  input  logic       vga_clk,
  input  logic       reset_n,
  input  logic       frame_start,
  input  logic       key_left,
  input  logic       key_right,
  input  logic       key_jump,
  output logic [9:0] SpriteX,
  output logic [9:0] SpriteY,
  output logic [1:0] anim_state,
  output logic [1:0] anim_frame,
  output logic       facing_left,
  output logic       update_done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_AIR  = 2'd2
  } state_e;

  localparam int DIV_W = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;

  localparam logic signed [10:0] X_MIN_S    = 11'(X_MIN);
  localparam logic signed [10:0] X_MAX_S    = 11'(X_MAX);
  localparam logic signed [10:0] STEP_S     = 11'(RUN_STEP);
  localparam logic signed [10:0] Y_GROUND_S = 11'(Y_GROUND);
  localparam logic        [9:0]  Y_TAKEOFF  = 10'(Y_GROUND - JUMP_V);
  localparam logic signed [7:0]  VY_TAKEOFF = 8'(GRAVITY - JUMP_V);
  localparam logic signed [7:0]  GRAV_S     = 8'(GRAVITY);
  localparam logic [DIV_W-1:0]   DIV_LAST   = DIV_W'(ANIM_DIV - 1);
  localparam logic [1:0]         FRAME_LAST = 2'(RUN_FRAMES - 1);

  state_e                state_q, state_d;
  logic [9:0]            x_q, x_d;
  logic [9:0]            y_q, y_d;
  logic signed [7:0]     vy_q, vy_d;
  logic [DIV_W-1:0]      div_q, div_d;
  logic [1:0]            frame_q, frame_d;
  logic                  face_q, face_d;
  logic                  jump_prev_q, jump_prev_d;
  logic                  done_q, done_d;

  logic                  dir_l, dir_r, dir_any, jump_edge;
  logic signed [10:0]    x_cur, x_sum, ny;
  logic [9:0]            x_next;
  logic signed [7:0]     vy_inc;
  logic [DIV_W-1:0]      div_base;
  logic [1:0]            frame_base;

  // Both keys together cancel out.
  assign dir_r     = key_right & ~key_left;
  assign dir_l     = key_left & ~key_right;
  assign dir_any   = dir_r | dir_l;
  assign jump_edge = key_jump & ~jump_prev_q;

  assign x_cur  = $signed({1'b0, x_q});
  assign x_sum  = dir_r ? (x_cur + STEP_S) : (dir_l ? (x_cur - STEP_S) : x_cur);
  assign x_next = (x_sum < X_MIN_S) ? 10'(X_MIN) :
                  (x_sum > X_MAX_S) ? 10'(X_MAX) : x_sum[9:0];

  assign ny     = $signed({1'b0, y_q}) + $signed({{3{vy_q[7]}}, vy_q});
  assign vy_inc = vy_q + GRAV_S;

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    vy_d        = vy_q;
    div_d       = div_q;
    frame_d     = frame_q;
    face_d      = face_q;
    jump_prev_d = jump_prev_q;
    done_d      = frame_start;
    div_base    = div_q;
    frame_base  = frame_q;

    if (frame_start) begin
      jump_prev_d = key_jump;
      x_d         = x_next;
      if (dir_any) face_d = dir_l;

      case (state_q)
        ST_AIR: begin
          // A pending jump press is deliberately ignored on the landing update.
          if (ny >= Y_GROUND_S) begin
            y_d     = 10'(Y_GROUND);
            vy_d    = '0;
            state_d = dir_any ? ST_RUN : ST_IDLE;
          end else if (ny < 11'sd0) begin
            y_d  = '0;
            vy_d = '0;
          end else begin
            y_d  = ny[9:0];
            vy_d = vy_inc;
          end
        end
        default: begin
          if (jump_edge) begin
            state_d = ST_AIR;
            y_d     = Y_TAKEOFF;
            vy_d    = VY_TAKEOFF;
          end else begin
            state_d = dir_any ? ST_RUN : ST_IDLE;
          end
        end
      endcase

      case (state_d)
        ST_RUN: begin
          // The entering update restarts the cycle from zero and is itself
          // counted, so the first frame change lands on the ANIM_DIV-th update.
          if (state_q != ST_RUN) begin
            div_base   = '0;
            frame_base = '0;
          end
          if (div_base == DIV_LAST) begin
            div_d   = '0;
            frame_d = (frame_base == FRAME_LAST) ? 2'd0 : frame_base + 2'd1;
          end else begin
            div_d   = div_base + DIV_W'(1);
            frame_d = frame_base;
          end
        end
        ST_AIR: begin
          div_d   = '0;
          frame_d = vy_d[7] ? 2'd0 : 2'd1;
        end
        default: begin
          div_d   = '0;
          frame_d = 2'd0;
        end
      endcase
    end
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      x_q         <= 10'(X_START);
      y_q         <= 10'(Y_GROUND);
      vy_q        <= '0;
      div_q       <= '0;
      frame_q     <= '0;
      face_q      <= 1'b0;
      jump_prev_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      vy_q        <= vy_d;
      div_q       <= div_d;
      frame_q     <= frame_d;
      face_q      <= face_d;
      jump_prev_q <= jump_prev_d;
      done_q      <= done_d;
    end
  end

  assign SpriteX     = x_q;
  assign SpriteY     = y_q;
  assign anim_state  = state_q;
  assign anim_frame  = frame_q;
  assign facing_left = face_q;
  assign update_done = done_q;

endmodule

// File: tb/tb_fighter_motion_ctrl.sv
module tb_fighter_motion_ctrl;

  localparam int X_START    = 100;
  localparam int X_MIN      = 0;
  localparam int X_MAX      = 599;
  localparam int Y_GROUND   = 400;
  localparam int RUN_STEP   = 2;
  localparam int JUMP_V     = 12;
  localparam int GRAVITY    = 1;
  localparam int ANIM_DIV   = 6;
  localparam int RUN_FRAMES = 4;

  localparam int M_IDLE = 0, M_RUN = 1, M_AIR = 2;

  logic       vga_clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       frame_start = 1'b0;
  logic       key_left = 1'b0, key_right = 1'b0, key_jump = 1'b0;
  logic [9:0] SpriteX, SpriteY;
  logic [1:0] anim_state, anim_frame;
  logic       facing_left, update_done;

  fighter_motion_ctrl #(
    .X_START(X_START), .X_MIN(X_MIN), .X_MAX(X_MAX), .Y_GROUND(Y_GROUND),
    .RUN_STEP(RUN_STEP), .JUMP_V(JUMP_V), .GRAVITY(GRAVITY),
    .ANIM_DIV(ANIM_DIV), .RUN_FRAMES(RUN_FRAMES)
  ) dut (
    .vga_clk(vga_clk), .reset_n(reset_n), .frame_start(frame_start),
    .key_left(key_left), .key_right(key_right), .key_jump(key_jump),
    .SpriteX(SpriteX), .SpriteY(SpriteY), .anim_state(anim_state),
    .anim_frame(anim_frame), .facing_left(facing_left), .update_done(update_done)
  );

  always #5 vga_clk = ~vga_clk;

  int n_tests = 0;
  int n_fail  = 0;
  int done_cnt = 0;

  always @(negedge vga_clk) if (update_done === 1'b1) done_cnt++;

  task automatic check_val(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model: plain integer kinematics; the run cycle is derived from
  // how many consecutive RUN updates have happened.
  int m_x, m_y, m_vy, m_st, m_frame, m_face, m_jp, m_run_cnt;

  task automatic model_reset();
    m_x = X_START; m_y = Y_GROUND; m_vy = 0; m_st = M_IDLE;
    m_frame = 0; m_face = 0; m_jp = 0; m_run_cnt = 0;
  endtask

  task automatic model_step(input bit l, input bit r, input bit j);
    int dir, nx, ny, prev_st;
    bit je;
    dir = (r && !l) ? 1 : ((l && !r) ? -1 : 0);
    je  = j && !m_jp;
    m_jp = j;
    prev_st = m_st;
    nx = m_x + dir * RUN_STEP;
    if (nx < X_MIN) nx = X_MIN;
    if (nx > X_MAX) nx = X_MAX;
    m_x = nx;
    if (dir != 0) m_face = (dir < 0) ? 1 : 0;
    if (m_st != M_AIR) begin
      if (je) begin
        m_st = M_AIR; m_y = Y_GROUND - JUMP_V; m_vy = GRAVITY - JUMP_V;
      end else m_st = (dir != 0) ? M_RUN : M_IDLE;
    end else begin
      ny = m_y + m_vy;
      if (ny >= Y_GROUND) begin
        m_y = Y_GROUND; m_vy = 0; m_st = (dir != 0) ? M_RUN : M_IDLE;
      end else if (ny < 0) begin
        m_y = 0; m_vy = 0;
      end else begin
        m_y = ny; m_vy = m_vy + GRAVITY;
      end
    end
    if (m_st == M_RUN) begin
      m_run_cnt = (prev_st == M_RUN) ? m_run_cnt + 1 : 1;
      m_frame = (m_run_cnt / ANIM_DIV) % RUN_FRAMES;
    end else begin
      m_run_cnt = 0;
      m_frame = (m_st == M_AIR) ? ((m_vy < 0) ? 0 : 1) : 0;
    end
  endtask

  task automatic check_outputs(input string tag);
    check_val({tag, ".x"},     int'(SpriteX),     m_x);
    check_val({tag, ".y"},     int'(SpriteY),     m_y);
    check_val({tag, ".state"}, int'(anim_state),  m_st);
    check_val({tag, ".frame"}, int'(anim_frame),  m_frame);
    check_val({tag, ".face"},  int'(facing_left), m_face);
  endtask

  task automatic do_update(input bit l, input bit r, input bit j);
    int gap;
    @(negedge vga_clk);
    key_left = l; key_right = r; key_jump = j;
    frame_start = 1'b1;
    @(posedge vga_clk);
    #1 frame_start = 1'b0;
    model_step(l, r, j);
    check_val("upd.done", int'(update_done), 1);
    check_outputs("upd");
    @(posedge vga_clk);
    #1;
    check_val("idle.done", int'(update_done), 0);
    check_val("idle.x", int'(SpriteX), m_x);
    check_val("idle.y", int'(SpriteY), m_y);
    gap = $urandom_range(0, 2);
    repeat (gap) @(posedge vga_clk);
  endtask

  task automatic check_reset_vals(input string tag);
    check_val({tag, ".x"},     int'(SpriteX), X_START);
    check_val({tag, ".y"},     int'(SpriteY), Y_GROUND);
    check_val({tag, ".state"}, int'(anim_state), 0);
    check_val({tag, ".frame"}, int'(anim_frame), 0);
    check_val({tag, ".face"},  int'(facing_left), 0);
    check_val({tag, ".done"},  int'(update_done), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int guard, d0;
    model_reset();
    repeat (3) @(posedge vga_clk);
    #1 check_reset_vals("rst");
    @(negedge vga_clk) reset_n = 1'b1;

    // Idle updates.
    d0 = done_cnt;
    for (int i = 0; i < 10; i++) do_update(0, 0, 0);
    check_val("idle10.pulses", done_cnt - d0, 10);
    check_val("idle10.x", int'(SpriteX), 100);
    check_val("idle10.y", int'(SpriteY), 400);

    // Run right 13 updates.
    for (int i = 1; i <= 13; i++) begin
      do_update(0, 1, 0);
      if (i == 5)  check_val("run.f5",  int'(anim_frame), 0);
      if (i == 6)  check_val("run.f6",  int'(anim_frame), 1);
      if (i == 11) check_val("run.f11", int'(anim_frame), 1);
      if (i == 12) check_val("run.f12", int'(anim_frame), 2);
    end
    check_val("run.x", int'(SpriteX), 126);
    check_val("run.state", int'(anim_state), 1);
    check_val("run.face", int'(facing_left), 0);

    // Jump from rest.
    do_update(0, 0, 0);
    for (int i = 1; i <= 25; i++) begin
      do_update(0, 0, (i == 1));
      if (i == 1) begin
        check_val("jump.y1", int'(SpriteY), 388);
        check_val("jump.st1", int'(anim_state), 2);
        check_val("jump.f1", int'(anim_frame), 0);
      end
      if (i == 12) begin
        check_val("jump.apex_y", int'(SpriteY), 322);
        check_val("jump.apex_f", int'(anim_frame), 1);
      end
    end
    check_val("jump.land_y", int'(SpriteY), 400);
    check_val("jump.land_st", int'(anim_state), 0);

    // Jump held: only one takeoff.
    for (int i = 0; i < 30; i++) do_update(0, 0, 1);
    check_val("hold.st", int'(anim_state), 0);
    check_val("hold.y", int'(SpriteY), 400);
    do_update(0, 0, 0);
    do_update(0, 0, 1);
    check_val("repress.st", int'(anim_state), 2);
    guard = 0;
    while (m_st == M_AIR && guard < 40) begin do_update(0, 0, 0); guard++; end
    check_val("repress.landed", int'(anim_state), 0);

    // Reset during a jump.
    for (int i = 1; i <= 5; i++) do_update(0, 0, (i == 1));
    check_val("midjump.st", int'(anim_state), 2);
    @(negedge vga_clk);
    #2 reset_n = 1'b0;
    #1 check_reset_vals("async_rst");
    model_reset();
    @(posedge vga_clk);
    #1 check_reset_vals("rst_held");
    @(negedge vga_clk) reset_n = 1'b1;

    // Right edge.
    guard = 0;
    while (m_x != 598 && guard < 400) begin do_update(0, 1, 0); guard++; end
    check_val("xmax.598", int'(SpriteX), 598);
    do_update(0, 1, 0);
    check_val("xmax.599", int'(SpriteX), 599);
    do_update(0, 1, 0);
    check_val("xmax.hold", int'(SpriteX), 599);

    // Left edge.
    guard = 0;
    while (m_x != 3 && guard < 400) begin do_update(1, 0, 0); guard++; end
    check_val("xmin.3", int'(SpriteX), 3);
    do_update(1, 0, 0);
    check_val("xmin.1", int'(SpriteX), 1);
    do_update(1, 0, 0);
    check_val("xmin.0", int'(SpriteX), 0);
    do_update(1, 0, 0);
    check_val("xmin.hold", int'(SpriteX), 0);
    check_val("xmin.face", int'(facing_left), 1);
    do_update(1, 1, 0);
    check_val("both.st", int'(anim_state), 0);
    check_val("both.face", int'(facing_left), 1);

    // frame_start held for three cycles performs three updates.
    @(negedge vga_clk);
    key_left = 1'b0; key_right = 1'b1; key_jump = 1'b0;
    frame_start = 1'b1;
    repeat (3) @(posedge vga_clk);
    #1 frame_start = 1'b0;
    repeat (3) model_step(0, 1, 0);
    check_outputs("multi");

    // Randomized play.
    for (int i = 0; i < 300; i++) begin
      bit l, r, j;
      l = 1'($urandom_range(0, 1));
      r = 1'($urandom_range(0, 1));
      j = ($urandom_range(0, 3) == 0);
      do_update(l, r, j);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
